// File: rtl/gf_inv_if.sv
// Operation bus for the GF(2^8) inverter. The requester drives en and i_state.
// The inverter drives the result and the status flags.
interface gf_inv_if;
  logic       en;
  logic [7:0] i_state;
  logic [7:0] o_state;
  logic       o_done;
  logic       o_busy;

  modport master (output en, i_state, input o_state, o_done, o_busy);
  modport slave  (input en, i_state, output o_state, o_done, o_busy);
endinterface

// File: rtl/gf_inv.sv
// Iterative GF(2^8) inverter: o_state = i_state^254, computed by square-and-multiply.
// All arithmetic goes through one bit-serial multiplier, one bit per cycle.
// Every run has the same length: 8 squares + 7 multiplies = 120 cycles.
module gf_inv #(
  parameter logic [8:0] POLY = 9'h11B
) (
  input  logic      clk,
  input  logic      rst,
  gf_inv_if.slave   bus
);

  // The exponent 254 is scanned MSB first; a 1 bit adds a multiply by the operand.
  localparam logic [7:0] EXPONENT = 8'hFE;

  typedef enum logic [2:0] {IDLE, SQR, MUL, DONE, HOLD} state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_a;
  logic [7:0] r_r;
  logic [7:0] r_acc;
  logic [2:0] r_bit_cnt;
  logic [2:0] r_exp_idx;
  logic [7:0] r_o_state;

  logic [7:0] w_y;
  logic [7:0] w_acc_next;
  logic       w_last_bit;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? POLY[7:0] : 8'h00);
  endfunction

  // Multiplier step, MSB of Y first: shift the accumulator, then add X if the Y bit is set.
  // X is always r. Y is r when squaring and the captured operand when multiplying.
  assign w_y        = (r_state == MUL) ? r_a : r_r;
  assign w_acc_next = xtime(r_acc) ^ (w_y[r_bit_cnt] ? r_r : 8'h00);
  assign w_last_bit = (r_bit_cnt == 3'd0);

  // State register; reset is synchronous and wins over en.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment, so every flop
    // samples the values that were present before the edge.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode; dropping en during SQR or MUL aborts the run.
  always_comb begin
    // NOTE: give the default first so that no path leaves w_state_next unassigned
    // (an unassigned path would infer a latch).
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (bus.en) w_state_next = SQR;
      SQR: begin
        if (!bus.en)                   w_state_next = IDLE;
        else if (w_last_bit) begin
          if (EXPONENT[r_exp_idx])     w_state_next = MUL;
          else if (r_exp_idx == 3'd0)  w_state_next = DONE;
        end
      end
      MUL: begin
        if (!bus.en)                   w_state_next = IDLE;
        else if (w_last_bit)           w_state_next = (r_exp_idx == 3'd0) ? DONE : SQR;
      end
      DONE: w_state_next = HOLD;
      HOLD: if (!bus.en) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: capture the operand, run the multiplier steps, publish the result on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: all datapath registers are small flops, not memory, so each one
      // is cleared by reset to give a known state after reset.
      r_a       <= 8'h00;
      r_r       <= 8'h00;
      r_acc     <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_exp_idx <= 3'd0;
      r_o_state <= 8'h00;
    end else begin
      case (r_state)
        IDLE: if (bus.en) begin
          r_a       <= bus.i_state;
          r_r       <= 8'h01;
          r_acc     <= 8'h00;
          r_bit_cnt <= 3'd7;
          r_exp_idx <= 3'd7;
        end
        SQR, MUL: if (bus.en) begin
          if (w_last_bit) begin
            r_r       <= w_acc_next;
            r_acc     <= 8'h00;
            r_bit_cnt <= 3'd7;
            // A square that is followed by a multiply keeps the index for that multiply.
            if (r_exp_idx != 3'd0 && (r_state == MUL || !EXPONENT[r_exp_idx]))
              r_exp_idx <= r_exp_idx - 3'd1;
            if (w_state_next == DONE)
              r_o_state <= w_acc_next;
          end else begin
            r_acc     <= w_acc_next;
            r_bit_cnt <= r_bit_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_state = r_o_state;
  assign bus.o_done  = (r_state == DONE);
  assign bus.o_busy  = (r_state == SQR) || (r_state == MUL);

endmodule
